// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl: latches a master key and streams round-key triples (i-1, i, i+1) over valid/ready, stepping i up or down.
module key_sched_ctrl #(
    parameter int ROUNDS = 16,
    parameter int KEY_W  = 144,
    parameter int SUB_W  = 9,
    parameter int IDX_W  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    input  logic             start,
    input  logic             dir,
    input  logic             abort,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [IDX_W-1:0] rk_idx,
    output logic [SUB_W-1:0] rk_prev,
    output logic [SUB_W-1:0] rk_cur,
    output logic [SUB_W-1:0] rk_next,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t state, state_n;
    logic [KEY_W-1:0] key_r;
    logic dir_r, fire, at_last, load;
    logic [IDX_W-1:0] idx, last, step_idx, load_idx;
    // subword index j = -i mod 16, so round 0 and every multiple of 16 use key word 0
    function automatic logic [SUB_W-1:0] sub(input logic [KEY_W-1:0] k, input logic [IDX_W-1:0] i);
        logic [3:0] j;
        j = 4'd0 - i[3:0];
        return k[SUB_W*j +: SUB_W] ^ SUB_W'(i);
    endfunction
    always_comb begin
        fire     = rk_valid & rk_ready;
        last     = dir_r ? IDX_W'(1) : IDX_W'(ROUNDS);
        at_last  = idx == last;
        step_idx = dir_r ? idx - 1'b1 : idx + 1'b1;
        load     = state == LOAD || (state == RUN && fire && !at_last);
        load_idx = state == LOAD ? idx : step_idx;
        state_n  = state;
        case (state)
            IDLE:    if (start) state_n = LOAD;
            LOAD:    state_n = RUN;
            RUN:     if (fire && at_last) state_n = DONE;
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            key_r    <= '0;
            dir_r    <= 1'b0;
            idx      <= '0;
            rk_idx   <= '0;
            rk_prev  <= '0;
            rk_cur   <= '0;
            rk_next  <= '0;
            rk_valid <= 1'b0;
        end else begin
            state    <= state_n;
            rk_valid <= state_n == RUN;
            if (!abort) begin
                if (state == IDLE && start) begin
                    key_r <= key_in;
                    dir_r <= dir;
                    idx   <= dir ? IDX_W'(ROUNDS) : IDX_W'(1);
                end
                if (load) begin
                    idx     <= load_idx;
                    rk_idx  <= load_idx;
                    rk_prev <= sub(key_r, load_idx - 1'b1);
                    rk_cur  <= sub(key_r, load_idx);
                    rk_next <= sub(key_r, load_idx + 1'b1);
                end
            end
        end
    end
    assign busy = state != IDLE;
    assign done = state == DONE;
endmodule

// File: tb/tb_key_sched_ctrl.sv
// tb_key_sched_ctrl: directed and randomized runs of key_sched_ctrl checked against an arithmetic model of the round-key rule.
module tb_key_sched_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [143:0] key_in = '0;
    logic start = 1'b0, dir = 1'b0, abort = 1'b0, rk_ready = 1'b0;
    logic busy, rk_valid, done;
    logic [6:0] rk_idx;
    logic [8:0] rk_prev, rk_cur, rk_next;
    int kw[16];
    int n_chk = 0, n_fail = 0;
    int f_idx, f_prev, f_cur, f_next;

    key_sched_ctrl #(.ROUNDS(16)) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .start(start), .dir(dir), .abort(abort),
        .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_idx(rk_idx),
        .rk_prev(rk_prev), .rk_cur(rk_cur), .rk_next(rk_next), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // round i uses key word (16 - i mod 16) mod 16, xored with i itself
    function automatic int model_sub(input int i);
        int m, j;
        m = ((i % 128) + 128) % 128;
        j = (16 - (m % 16)) % 16;
        return (kw[j] ^ m) & 'h1ff;
    endfunction

    task automatic set_key();
        for (int k = 0; k < 16; k++) key_in[9*k +: 9] = 9'(kw[k]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_run(input bit d, input int rdy_pct, input int hold_idx);
        int beat, budget, held, e;
        beat = 0; budget = 0; held = 0;
        set_key();
        dir = d;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("load_busy", int'(busy), 1);
        chk("load_valid", int'(rk_valid), 0);
        step();
        f_idx = int'(rk_idx); f_prev = int'(rk_prev); f_cur = int'(rk_cur); f_next = int'(rk_next);
        while (beat < 16 && budget < 400) begin
            e = d ? 16 - beat : beat + 1;
            chk("valid", int'(rk_valid), 1);
            chk("busy", int'(busy), 1);
            chk("done_early", int'(done), 0);
            chk("idx", int'(rk_idx), e);
            chk("prev", int'(rk_prev), model_sub(e - 1));
            chk("cur", int'(rk_cur), model_sub(e));
            chk("next", int'(rk_next), model_sub(e + 1));
            rk_ready = $urandom_range(99) < rdy_pct;
            if (e == hold_idx && held < 5) begin
                rk_ready = 1'b0;
                held++;
            end
            start = $urandom_range(3) == 0;
            dir = 1'($urandom);
            for (int k = 0; k < 16; k++) key_in[9*k +: 9] = 9'($urandom);
            step();
            if (rk_ready) beat++;
            budget++;
        end
        chk("beats", beat, 16);
        start = 1'b0;
        rk_ready = 1'b0;
        chk("done_pulse", int'(done), 1);
        chk("done_valid", int'(rk_valid), 0);
        chk("done_busy", int'(busy), 1);
        step();
        chk("done_clear", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
    endtask

    initial begin
        int budget;
        for (int k = 0; k < 16; k++) kw[k] = k;
        step();
        step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(rk_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_idx", int'(rk_idx), 0);
        chk("rst_prev", int'(rk_prev), 0);
        chk("rst_cur", int'(rk_cur), 0);
        chk("rst_next", int'(rk_next), 0);
        rst_n = 1'b1;
        step();

        do_run(1'b0, 100, 0);
        chk("t1_idx", f_idx, 1);
        chk("t1_prev", f_prev, 'h000);
        chk("t1_cur", f_cur, 'h00e);
        chk("t1_next", f_next, 'h00c);

        do_run(1'b1, 100, 0);
        chk("t2_idx", f_idx, 16);
        chk("t2_prev", f_prev, 'h00e);
        chk("t2_cur", f_cur, 'h010);
        chk("t2_next", f_next, 'h01e);

        do_run(1'b0, 100, 3);

        set_key();
        dir = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        rk_ready = 1'b1;
        step();
        budget = 0;
        while (rk_idx != 7'd7 && budget < 50) begin
            step();
            budget++;
        end
        chk("t4_reach7", int'(rk_idx), 7);
        abort = 1'b1;
        start = 1'b1;
        rk_ready = 1'b0;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("t4_valid", int'(rk_valid), 0);
        chk("t4_busy", int'(busy), 0);
        chk("t4_done", int'(done), 0);
        chk("t4_hold_idx", int'(rk_idx), 7);
        chk("t4_hold_cur", int'(rk_cur), model_sub(7));
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t4_no_done", int'(done), 0);
            chk("t4_idle", int'(busy), 0);
        end
        do_run(1'b1, 70, 0);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 16; k++) kw[k] = int'($urandom_range(511));
            do_run(1'($urandom), int'($urandom_range(100, 30)), int'($urandom_range(16, 1)));
        end

        for (int k = 0; k < 16; k++) kw[k] = k;
        set_key();
        dir = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        rk_ready = 1'b1;
        step();
        step();
        step();
        #3 rst_n = 1'b0;
        #1;
        chk("t6_busy", int'(busy), 0);
        chk("t6_valid", int'(rk_valid), 0);
        chk("t6_done", int'(done), 0);
        chk("t6_idx", int'(rk_idx), 0);
        chk("t6_prev", int'(rk_prev), 0);
        chk("t6_cur", int'(rk_cur), 0);
        chk("t6_next", int'(rk_next), 0);
        rk_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        do_run(1'b0, 100, 0);
        chk("t6_first_idx", f_idx, 1);
        chk("t6_first_cur", f_cur, 'h00e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
